// File: rtl/uart_pkg.sv
// Shared register map, bit indices and TX FSM state type for the UART FIFO controller.
package uart_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_CONTROL  = 3'd2;
  localparam logic [2:0] REG_RX_LEVEL = 3'd3;
  localparam logic [2:0] REG_DIV_LO   = 3'd4;
  localparam logic [2:0] REG_DIV_HI   = 3'd5;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_TX_ACTIVE    = 4;
  localparam int ST_RX_OVERRUN   = 5;
  localparam int ST_RX_ERROR     = 6;
  localparam int ST_TX_OVERFLOW  = 7;

  localparam int CTRL_RX_IE  = 0;
  localparam int CTRL_TX_IE  = 1;
  localparam int CTRL_ERR_IE = 2;
  localparam int CTRL_LOOP   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output; push on full is accepted only
// when a pop frees a slot in the same cycle, pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= din;
  end

  // Pointers are exactly AW bits wide so they wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Bus-facing UART controller: TX/RX FIFOs, baud divisor, sticky errors, level IRQ.
// Optional TX->RX loopback via CONTROL[3] when UART_LOOPBACK_EN is defined.
import uart_pkg::*;

module uart_fifo_ctrl #(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs,
  input  logic             rwb,
  input  logic [2:0]       addr,
  input  logic [7:0]       i_data,
  output logic [7:0]       o_data,
  output logic             irqb,
  output logic [7:0]       tx_data_o,
  output logic             tx_en_o,
  input  logic             tx_busy_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             rx_error_i,
  output logic [DIV_W-1:0] baud_div_o
);

  localparam int TXC_W = $clog2(TX_DEPTH) + 1;
  localparam int RXC_W = $clog2(RX_DEPTH) + 1;

  logic wr_acc, rd_acc, data_wr, data_rd, status_wr, ctrl_wr;

  assign wr_acc    = cs & ~rwb;
  assign rd_acc    = cs & rwb;
  assign data_wr   = wr_acc & (addr == REG_DATA);
  assign data_rd   = rd_acc & (addr == REG_DATA);
  assign status_wr = wr_acc & (addr == REG_STATUS);
  assign ctrl_wr   = wr_acc & (addr == REG_CONTROL);

  logic [7:0]       tx_dout, rx_dout, rx_din;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [TXC_W-1:0] tx_count;
  logic [RXC_W-1:0] rx_count;
  logic             tx_pop, rx_push, rx_pop_eff;
  logic             fsm_pop, loop_pop, loop_on;

  logic [2:0]       ie_reg;
  logic [2:0]       sticky_reg;
  logic [2:0]       sticky_next;
  logic [2:0]       sticky_set;
  logic [2:0]       sticky_w1c;
  logic [DIV_W-1:0] baud_div_reg;
  logic [15:0]      div16;
  logic [7:0]       tx_data_reg;
  logic             irqb_reg;
  logic             irq_cause;
  logic [7:0]       status_val;
  tx_state_t        state_reg, state_next;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_wr),
    .pop     (tx_pop),
    .din     (i_data),
    .dout    (tx_dout),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (data_rd),
    .din     (rx_din),
    .dout    (rx_dout),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

`ifdef UART_LOOPBACK_EN
  logic loop_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      loop_reg <= 1'b0;
    else if (ctrl_wr)
      loop_reg <= i_data[CTRL_LOOP];
  end

  assign loop_on = loop_reg;
`else
  assign loop_on = 1'b0;
`endif

  // In loopback the TX head bypasses the core and lands in RX, one byte per cycle.
  assign loop_pop   = loop_on & ~tx_empty;
  assign tx_pop     = fsm_pop | loop_pop;
  assign rx_push    = loop_on ? loop_pop : rx_valid_i;
  assign rx_din     = loop_on ? tx_dout : rx_data_i;
  assign rx_pop_eff = data_rd & ~rx_empty;

  always_comb begin
    state_next = state_reg;
    fsm_pop    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!tx_empty && !loop_on) begin
          state_next = LOAD;
          fsm_pop    = 1'b1;
        end
      end
      LOAD:    if (tx_busy_i)  state_next = DRAIN;
      DRAIN:   if (!tx_busy_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      tx_data_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (fsm_pop)
        tx_data_reg <= tx_dout;
    end
  end

  assign tx_en_o   = (state_reg == LOAD);
  assign tx_data_o = tx_data_reg;

  // Bits ordered as STATUS[7:5]: tx_overflow, rx_error, rx_overrun.
  assign sticky_set[2] = data_wr & tx_full & ~tx_pop;
  assign sticky_set[1] = ~loop_on & rx_valid_i & rx_error_i;
  assign sticky_set[0] = rx_push & rx_full & ~rx_pop_eff;
  assign sticky_w1c    = status_wr ? i_data[7:5] : 3'b000;
  assign sticky_next   = (sticky_reg & ~sticky_w1c) | sticky_set;

  assign div16 = 16'(baud_div_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_reg   <= 3'b000;
      ie_reg       <= 3'b000;
      baud_div_reg <= DIV_W'(DEFAULT_DIV);
      irqb_reg     <= 1'b1;
    end else begin
      sticky_reg <= sticky_next;
      if (ctrl_wr)
        ie_reg <= i_data[2:0];
      if (wr_acc && addr == REG_DIV_LO)
        baud_div_reg <= DIV_W'({div16[15:8], i_data});
      else if (wr_acc && addr == REG_DIV_HI)
        baud_div_reg <= DIV_W'({i_data, div16[7:0]});
      irqb_reg <= ~irq_cause;
    end
  end

  assign irq_cause = (ie_reg[CTRL_RX_IE]  & ~rx_empty)
                   | (ie_reg[CTRL_TX_IE]  & tx_empty & (state_reg == IDLE))
                   | (ie_reg[CTRL_ERR_IE] & (|sticky_reg));

  assign irqb       = irqb_reg;
  assign baud_div_o = baud_div_reg;

  assign status_val = {sticky_reg, (state_reg != IDLE), tx_full, tx_empty,
                       rx_full, ~rx_empty};

  always_comb begin
    o_data = 8'h00;
    case (addr)
      REG_DATA:     o_data = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS:   o_data = status_val;
      REG_CONTROL:  o_data = {4'b0000, loop_on, ie_reg};
      REG_RX_LEVEL: o_data = 8'(rx_count);
      REG_DIV_LO:   o_data = div16[7:0];
      REG_DIV_HI:   o_data = div16[15:8];
      default:      o_data = 8'h00;
    endcase
  end

  // TX occupancy is visible only through the empty/full flags.
  logic tx_count_unused;
  assign tx_count_unused = ^tx_count;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl with TX/RX scoreboards and a simple core model.
// Loopback checks are compiled in when UART_LOOPBACK_EN is defined.
`timescale 1ns/1ps
import uart_pkg::*;

module tb_uart_fifo_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cs;
  logic        rwb;
  logic [2:0]  addr;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        irqb;
  logic [7:0]  tx_data_o;
  logic        tx_en_o;
  logic        tx_busy_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_error_i;
  logic [15:0] baud_div_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_exp [$];
  logic [7:0] rx_q   [$];

  logic mon_en  = 1'b0;
  logic saw_en  = 1'b0;

  uart_fifo_ctrl #(
    .TX_DEPTH(16), .RX_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(27)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .rwb        (rwb),
    .addr       (addr),
    .i_data     (i_data),
    .o_data     (o_data),
    .irqb       (irqb),
    .tx_data_o  (tx_data_o),
    .tx_en_o    (tx_en_o),
    .tx_busy_i  (tx_busy_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_error_i (rx_error_i),
    .baud_div_o (baud_div_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mon_en && tx_en_o)
      saw_en <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
    @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b1; addr = a;
    #1 d = o_data;
    @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d, input logic err);
    @(negedge clk);
    rx_valid_i = 1'b1; rx_data_i = d; rx_error_i = err;
    if (rx_q.size() < 16)
      rx_q.push_back(d);
    @(posedge clk);
    #1 rx_valid_i = 1'b0; rx_error_i = 1'b0;
  endtask

  task automatic read_data_sb(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    bus_read(REG_DATA, d);
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    check(tag, d, exp);
  endtask

  // Core model: raise busy two cycles after a request, hold it for ten cycles.
  initial begin
    tx_busy_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_en_o) begin
        if (tx_exp.size() == 0)
          check("tx_unexpected", {24'h0, tx_data_o}, 32'h100);
        else
          check("tx_data", tx_data_o, tx_exp.pop_front());
        @(posedge clk); #1 check("tx_en_hold1", tx_en_o, 1);
        @(posedge clk); #1 check("tx_en_hold2", tx_en_o, 1);
        tx_busy_i = 1'b1;
        @(posedge clk); #1 check("tx_en_drop", tx_en_o, 0);
        repeat (9) @(posedge clk);
        #1 tx_busy_i = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp;
    int cnt;

    reset_n = 1'b0; cs = 1'b0; rwb = 1'b1; addr = 3'd0; i_data = 8'h00;
    rx_data_i = 8'h00; rx_valid_i = 1'b0; rx_error_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_irqb", irqb, 1);
    check("rst_baud", baud_div_o, 27);
    check("rst_tx_en", tx_en_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    bus_read(REG_STATUS, d);   check("rst_status", d, 8'h04);
    bus_read(REG_CONTROL, d);  check("rst_control", d, 8'h00);
    bus_read(REG_RX_LEVEL, d); check("rst_rx_level", d, 8'h00);
    bus_read(REG_DATA, d);     check("rx_empty_read", d, 8'h00);

    // TX path: three back-to-back bytes
    for (int i = 0; i < 3; i++) begin
      tx_exp.push_back(8'(8'h41 + i));
      bus_write(REG_DATA, 8'(8'h41 + i));
    end
    bus_read(REG_STATUS, d); check("tx_busy_status", d, 8'h10);
    cnt = 0;
    while (tx_exp.size() != 0 && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    check("tx_drain_in_time", (cnt < 500), 1);
    bus_read(REG_STATUS, d); check("tx_last_popped_status", d, 8'h14);
    repeat (20) @(negedge clk);
    bus_read(REG_STATUS, d); check("tx_done_status", d, 8'h04);

    // Divisor registers
    bus_write(REG_DIV_LO, 8'h34); check("div_lo_out", baud_div_o, 16'h0034);
    bus_write(REG_DIV_HI, 8'h12); check("div_hi_out", baud_div_o, 16'h1234);
    bus_read(REG_DIV_LO, d); check("div_lo_rd", d, 8'h34);
    bus_read(REG_DIV_HI, d); check("div_hi_rd", d, 8'h12);
    bus_write(3'd6, 8'hFF);
    bus_read(3'd6, d); check("reg6_rd", d, 8'h00);

    // RX overrun: 17 pulses into a 16-entry FIFO
    for (int i = 0; i < 17; i++)
      rx_pulse(8'(i), 1'b0);
    bus_read(REG_RX_LEVEL, d); check("rx_level_full", d, 8'd16);
    bus_read(REG_STATUS, d);   check("rx_overrun_status", d, 8'h27);
    for (int i = 0; i < 16; i++)
      read_data_sb("rx_fill_data");
    bus_read(REG_DATA, d); check("rx_lost_byte", d, 8'h00);
    bus_write(REG_STATUS, 8'h20);
    bus_read(REG_STATUS, d); check("overrun_w1c", d, 8'h04);

    // RX error flag: byte kept, flag sticky until W1C
    rx_pulse(8'h77, 1'b1);
    bus_read(REG_STATUS, d); check("rx_error_status", d, 8'h45);
    read_data_sb("rx_error_data");
    bus_write(REG_STATUS, 8'h40);
    bus_read(REG_STATUS, d); check("rx_error_w1c", d, 8'h04);

    // RX interrupt
    bus_write(REG_CONTROL, 8'h01);
    rx_pulse(8'h5A, 1'b0);
    check("irq_not_yet", irqb, 1);
    @(posedge clk); #1 check("irq_rx_low", irqb, 0);
    read_data_sb("irq_rx_data");
    check("irq_still_low", irqb, 0);
    @(posedge clk); #1 check("irq_released", irqb, 1);
    bus_write(REG_CONTROL, 8'h02);
    @(posedge clk); #1 check("irq_tx_low", irqb, 0);
    bus_write(REG_CONTROL, 8'h00);
    @(posedge clk); #1 check("irq_tx_release", irqb, 1);

    // Full RX FIFO with push and pop in the same cycle
    for (int i = 0; i < 16; i++)
      rx_pulse(8'(8'h30 + i), 1'b0);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b1; addr = REG_DATA;
    rx_valid_i = 1'b1; rx_data_i = 8'h99;
    #1 d = o_data;
    @(posedge clk);
    #1 cs = 1'b0; rx_valid_i = 1'b0;
    exp = rx_q.pop_front();
    rx_q.push_back(8'h99);
    check("simul_head", d, exp);
    bus_read(REG_RX_LEVEL, d); check("simul_level", d, 8'd16);
    bus_read(REG_STATUS, d);   check("simul_no_overrun", d, 8'h07);
    for (int i = 0; i < 16; i++)
      read_data_sb("simul_drain");

`ifdef UART_LOOPBACK_EN
    mon_en = 1'b1;
    bus_write(REG_CONTROL, 8'h08);
    bus_read(REG_CONTROL, d); check("loop_ctrl_rd", d, 8'h08);
    rx_q.push_back(8'h11); bus_write(REG_DATA, 8'h11);
    rx_q.push_back(8'h22); bus_write(REG_DATA, 8'h22);
    repeat (3) @(negedge clk);
    bus_read(REG_RX_LEVEL, d); check("loop_level", d, 8'd2);
    read_data_sb("loop_data");
    read_data_sb("loop_data");
    check("loop_no_tx_en", saw_en, 0);
    bus_write(REG_CONTROL, 8'h00);
    mon_en = 1'b0;
`else
    bus_write(REG_CONTROL, 8'h08);
    bus_read(REG_CONTROL, d); check("loop_bit_absent", d, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
